// File: rtl/sw_led_ctrl.sv
// Switch/LED controller: per-bit synchronise + debounce, then drive LEDs in one
// of four display modes (direct, toggle, blink, rotate).

module sw_led_deb #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_s,
  output logic sw_db
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sw_s != db_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) db_d = sw_s;
      else                              cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign sw_db = db_q;
endmodule

module sw_led_ctrl #(
  parameter int WIDTH      = 7,
  parameter int DEB_CYCLES = 1000000,
  parameter int TICK_DIV   = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic [WIDTH-1:0] sw_db
);
  localparam int TW = $clog2(TICK_DIV);

  logic [WIDTH-1:0] sync1_q, sw_s_q;
  logic [WIDTH-1:0] db_prev_q, rise;
  logic [WIDTH-1:0] tog_q, tog_d;
  logic [WIDTH-1:0] rot_q, rot_d, rot_l;
  logic [WIDTH-1:0] led_q, led_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick, phase_q, phase_d;
  logic [1:0]       mode_prev_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sw_led_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .sw_s  (sw_s_q[i]),
      .sw_db (sw_db[i])
    );
  end

  always_comb begin
    rise       = sw_db & ~db_prev_q;
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    phase_d    = phase_q ^ tick;
    tog_d      = tog_q ^ rise;

    rot_l = '0;
    for (int i = 0; i < WIDTH; i++) rot_l[i] = rot_q[(i + WIDTH - 1) % WIDTH];

    // Entering rotate reloads from the switches; an empty pattern seeds bit 0
    rot_d = rot_q;
    if (mode == 2'b11) begin
      if (mode_prev_q != 2'b11) rot_d = (sw_db == '0) ? WIDTH'(1) : sw_db;
      else if (tick)            rot_d = rot_l;
    end

    case (mode)
      2'b00:   led_d = sw_db;
      2'b01:   led_d = tog_q;
      2'b10:   led_d = phase_q ? sw_db : '0;
      default: led_d = rot_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sw_s_q      <= '0;
      db_prev_q   <= '0;
      tog_q       <= '0;
      rot_q       <= '0;
      led_q       <= '0;
      tick_cnt_q  <= '0;
      phase_q     <= 1'b0;
      mode_prev_q <= 2'b00;
    end else begin
      sync1_q     <= sw;
      sw_s_q      <= sync1_q;
      db_prev_q   <= sw_db;
      tog_q       <= tog_d;
      rot_q       <= rot_d;
      led_q       <= led_d;
      tick_cnt_q  <= tick_cnt_d;
      phase_q     <= phase_d;
      mode_prev_q <= mode;
    end
  end

  assign led = led_q;
endmodule

// File: tb/tb_sw_led_ctrl.sv
// Directed bench for sw_led_ctrl with WIDTH=7, DEB_CYCLES=4, TICK_DIV=4.

module tb_sw_led_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] sw = '0;
  logic [1:0] mode = 2'b00;
  logic [6:0] led, sw_db;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;

  sw_led_ctrl #(.WIDTH(7), .DEB_CYCLES(4), .TICK_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .mode  (mode),
    .led   (led),
    .sw_db (sw_db)
  );

  always #5 clk = ~clk;

  // edges since the last reset edge; tick counter in the DUT equals cyc % 4
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sw = '0; mode = 2'b00; rst = 1'b1;
    step(2);
    checks++;
    if (led !== 7'h00) begin failures++; $display("FAIL reset_led got=%h exp=00", led); end
    checks++;
    if (sw_db !== 7'h00) begin failures++; $display("FAIL reset_sw_db got=%h exp=00", sw_db); end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    logic [6:0] e_db, e_led;
    sw = '0; mode = 2'b00;
    do_reset();
    sw = 7'h55;
    for (int k = 0; k <= 6; k++) begin
      step(1);
      e_db  = (k >= 5) ? 7'h55 : 7'h00;
      e_led = (k >= 6) ? 7'h55 : 7'h00;
      checks++;
      if (sw_db !== e_db) begin failures++; $display("FAIL latency_db E%0d got=%h exp=%h", k, sw_db, e_db); end
      checks++;
      if (led !== e_led) begin failures++; $display("FAIL latency_led E%0d got=%h exp=%h", k, led, e_led); end
    end
  endtask

  task automatic test_bounce();
    sw = '0; mode = 2'b00;
    do_reset();
    sw = 7'h01;
    for (int k = 0; k < 11; k++) begin
      step(1);
      if (k == 2) sw = 7'h00;
      checks++;
      if (sw_db !== 7'h00 || led !== 7'h00) begin
        failures++; $display("FAIL bounce k=%0d db=%h led=%h exp=00", k, sw_db, led);
      end
    end
  endtask

  task automatic test_toggle();
    logic [6:0] exp_t [4] = '{7'h04, 7'h04, 7'h00, 7'h00};
    sw = '0; mode = 2'b01;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      sw = (p % 2 == 0) ? 7'h04 : 7'h00;
      step(10);
      checks++;
      if (led !== exp_t[p]) begin failures++; $display("FAIL toggle p=%0d got=%h exp=%h", p, led, exp_t[p]); end
    end
  endtask

  task automatic test_mode_change();
    sw = '0; mode = 2'b00;
    do_reset();
    sw = 7'h03;
    step(12);
    checks++;
    if (led !== 7'h03) begin failures++; $display("FAIL mc_direct got=%h exp=03", led); end
    mode = 2'b01;
    step(1);
    checks++;
    if (led !== 7'h03) begin failures++; $display("FAIL mc_tog got=%h exp=03", led); end
    sw = 7'h00;
    step(12);
    checks++;
    if (sw_db !== 7'h00 || led !== 7'h03) begin
      failures++; $display("FAIL mc_tog_hold db=%h led=%h exp db=00 led=03", sw_db, led);
    end
    mode = 2'b00;
    step(1);
    checks++;
    if (led !== 7'h00) begin failures++; $display("FAIL mc_back got=%h exp=00", led); end
    // rise of bit 0 coincides with the switch to toggle mode
    sw = 7'h01;
    step(6);
    mode = 2'b01;
    step(1);
    checks++;
    if (led !== 7'h03) begin failures++; $display("FAIL mc_same_edge got=%h exp=03", led); end
    step(1);
    checks++;
    if (led !== 7'h02) begin failures++; $display("FAIL mc_after_rise got=%h exp=02", led); end
  endtask

  task automatic test_rotate();
    logic [6:0] e, prev;
    int guard;
    sw = '0; mode = 2'b00;
    do_reset();
    sw = 7'h01;
    step(10);
    checks++;
    if (sw_db !== 7'h01) begin failures++; $display("FAIL rot_setup got=%h exp=01", sw_db); end
    guard = 0;
    while (cyc % 4 != 0 && guard < 8) begin step(1); guard++; end
    checks++;
    if (cyc % 4 != 0) begin failures++; $display("FAIL rot_align cyc=%0d exp mult of 4", cyc); end
    mode = 2'b11;
    step(1);
    e = 7'h01;
    checks++;
    if (led !== e) begin failures++; $display("FAIL rot_load got=%h exp=%h", led, e); end
    for (int s = 1; s <= 7; s++) begin
      prev = e;
      e = {e[5:0], e[6]};
      step(2);
      checks++;
      if (led !== prev) begin failures++; $display("FAIL rot_hold s=%0d got=%h exp=%h", s, led, prev); end
      step(2);
      checks++;
      if (led !== e) begin failures++; $display("FAIL rot_step s=%0d got=%h exp=%h", s, led, e); end
    end
  endtask

  task automatic test_blink();
    logic [6:0] e;
    sw = 7'h7F; mode = 2'b10;
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      step(1);
      e = ((((n - 1) / 4) % 2 == 1) && n >= 7) ? 7'h7F : 7'h00;
      checks++;
      if (led !== e) begin failures++; $display("FAIL blink n=%0d got=%h exp=%h", n, led, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] e_db, e_led;
    sw = '0; mode = 2'b00;
    do_reset();
    sw = 7'h01;
    step(10);
    mode = 2'b11;
    step(5);
    sw = 7'h7F;
    step(3);
    rst = 1'b1; mode = 2'b00;
    step(1);
    checks++;
    if (led !== 7'h00 || sw_db !== 7'h00) begin
      failures++; $display("FAIL mid_reset led=%h db=%h exp=00", led, sw_db);
    end
    rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step(1);
      e_db  = (n >= 6) ? 7'h7F : 7'h00;
      e_led = (n >= 7) ? 7'h7F : 7'h00;
      checks++;
      if (sw_db !== e_db || led !== e_led) begin
        failures++; $display("FAIL redeb n=%0d db=%h led=%h exp db=%h led=%h", n, sw_db, led, e_db, e_led);
      end
    end
    mode = 2'b01;
    step(1);
    checks++;
    if (led !== 7'h7F) begin failures++; $display("FAIL rise_after_reset got=%h exp=7f", led); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_toggle();
    test_mode_change();
    test_rotate();
    test_blink();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
